cipher_out_serializer: RTL and testbench
========================================

Name: cipher_out_serializer

Overview:
- Receiving end of the cipher stream-out interface (vout/tout/dout).
- Buffers 128-bit result blocks, which can arrive back-to-back with no backpressure.
- Emits each block as four 32-bit words on a valid/ready master port toward the host bus.
- Provides an almost-full flag so upstream input control can throttle, and a sticky overflow flag for dropped blocks.

Parameters:
- DEPTH, 4, number of 128-bit block entries in the buffer (power of two, ≥ 2)
- AW, 2, log2(DEPTH)
- AFULL_FREE, 1, afull asserts when free entries ≤ AFULL_FREE

Ports:
- clk  in  1  clock
- rst  in  1  reset
- vin  in  1  block valid (from cipher vout)
- tin  in  1  block type, 0 = encrypt result, 1 = decrypt result (from cipher tout)
- din  in  128  block data (from cipher dout)
- m_valid  out  1  output word valid
- m_ready  in  1  output word accepted by sink
- m_data  out  32  output word
- m_type  out  1  type of the block the current word belongs to
- m_last  out  1  current word is the final word of its block
- afull  out  1  buffer almost full
- level  out  AW+1  number of occupied block entries (0..DEPTH)
- overflow  out  1  sticky: a block was dropped
- clr_ovf  in  1  clears overflow

Behaviour:
- Reset: rst is synchronous, active-high; clock is clk.
  - Reset clears read/write pointers, level, word counter and overflow.
  - Reset values: m_valid=0, m_last=0, m_type=0, m_data=0, afull=0 (when AFULL_FREE < DEPTH), level=0, overflow=0.
  - Reset mid-block discards any partially sent block; no further words of it appear.
- Push: on a clk edge with vin=1, the block {tin, din} is written at the write pointer if accepted.
  - Accepted when level < DEPTH, or when level == DEPTH and a pop completes in the same cycle.
  - Write pointer wraps modulo DEPTH.
- Drop: vin=1 while full with no same-cycle pop → block discarded, overflow set to 1 next cycle.
  - Set has priority over a simultaneous clr_ovf.
  - Otherwise clr_ovf=1 clears overflow.
- Word order: most significant word first.
  - wcnt 0 → din[127:96], 1 → [95:64], 2 → [63:32], 3 → [31:0].
- Output signals:
  - m_valid = (level != 0).
  - m_data = head entry word selected by wcnt; m_type = head entry tin; m_last = (wcnt == 3) & m_valid.
  - Outputs are driven from registers only, with no combinational path from vin/din.
  - m_data, m_type and m_last are 0 when m_valid=0.
- Handshake: a word transfers on a clk edge with m_valid & m_ready.
  - wcnt increments on each transfer; the transfer at wcnt == 3 pops the head entry and resets wcnt to 0.
  - m_valid, once high, stays high and m_data stays stable until the word transfers.
- Latency: a block pushed at edge N gives m_valid=1 with word 0 in the cycle after edge N (buffer empty, no reset).
  - Sustained throughput is 1 word/cycle with m_ready=1, i.e. 1 block per 4 cycles.
- level: +1 on push only, −1 on pop only, unchanged on simultaneous push and pop. It never exceeds DEPTH.
- afull = (DEPTH − level) ≤ AFULL_FREE, registered alongside level.
- tin is carried per block, so mixed encrypt/decrypt streams stay ordered. There is no reordering.

Decomposition:
- Shared package (aes_stream_pkg) holds:
  - TYPE_OUT_ENC=1'b0 and TYPE_OUT_DEC=1'b1
  - BLK_W=128, WORD_W=32, WORDS_PER_BLK=4
- One sub-module, blk_fifo: synchronous FIFO with width 129 ({type, data}) and depth DEPTH.
  - Provides push, pop, head, level, full and empty.
  - Same-cycle push on full is allowed when pop is asserted.
- The top level holds the word counter, word mux, afull/overflow logic, and handshake.

Test Plan:
- Single block: vin=1, tin=0, din=0x00112233_44556677_8899AABB_CCDDEEFF, m_ready=1 → four words 0x00112233, 0x44556677, 0x8899AABB, 0xCCDDEEFF on consecutive cycles starting one cycle after push; m_last only on the 4th; m_type=0; level returns to 0.
- Backpressure: m_ready toggles 1,0,0,1,… on the same block → each word held stable while m_ready=0; no word duplicated or skipped; word order unchanged.
- Burst overflow: 6 back-to-back blocks (tin alternating 0/1, din=i) with m_ready=0 and DEPTH=4.
  - Required: level=4; afull=1 once level ≥ 3; overflow=1 after the 5th block.
  - After release, blocks 0..3 are emitted in order with correct m_type; blocks 4 and 5 never appear.
- Full with simultaneous pop: buffer full, last word of the head block transferring while vin=1 → new block accepted, level stays 4, overflow stays 0.
- Overflow clear priority: clr_ovf=1 in the same cycle as a dropped block → overflow stays 1; clr_ovf=1 alone next cycle → overflow=0.
- Reset mid-block: assert rst after 2 words of a block → next cycle m_valid=0, level=0, overflow=0; a block pushed after reset is emitted starting from its word 0.

Source files
------------

// File: rtl/aes_stream_pkg.sv
// aes_stream_pkg: shared types and constants for the cipher stream-out path
// Contents: block type codes, block/word widths, the buffered block record
// and a helper that picks one 32-bit word of a block, most significant first.
package aes_stream_pkg;
    localparam logic TYPE_OUT_ENC = 1'b0;
    localparam logic TYPE_OUT_DEC = 1'b1;
    localparam int BLK_W = 128;
    localparam int WORD_W = 32;
    localparam int WORDS_PER_BLK = 4;
    typedef struct packed {
        logic typ;
        logic [BLK_W-1:0] data;
    } blk_t;
    // Word 0 is data[127:96]; ~w turns word index into 32-bit slot index.
    function automatic logic [WORD_W-1:0] word_sel(input blk_t b, input logic [1:0] w);
        return b.data[{~w, 5'd0} +: WORD_W];
    endfunction
endpackage

// File: rtl/cipher_out_serializer_blk_fifo.sv
// blk_fifo: synchronous FIFO of {type, data} block records
// Ports: clk, rst (sync, active-high); push/wdata write at the tail;
// pop retires the head; head is the oldest entry; level/full/empty report occupancy.
// A push while full is legal only when pop is asserted in the same cycle.
module blk_fifo
    import aes_stream_pkg::*;
#(
    parameter int DEPTH = 4,
    parameter int AW = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        push,
    input  logic        pop,
    input  blk_t        wdata,
    output blk_t        head,
    output logic [AW:0] level,
    output logic        full,
    output logic        empty
);
    blk_t mem [DEPTH];
    logic [AW-1:0] wptr, rptr;
    always_ff @(posedge clk)
        if (push) mem[wptr] <= wdata;
    always_ff @(posedge clk) begin
        if (rst) begin
            wptr <= '0;
            rptr <= '0;
            level <= '0;
        end else begin
            if (push) wptr <= wptr + AW'(1);
            if (pop) rptr <= rptr + AW'(1);
            level <= level + (AW+1)'(push) - (AW+1)'(pop);
        end
    end
    assign head = mem[rptr];
    assign full = level == (AW+1)'(DEPTH);
    assign empty = level == '0;
endmodule

// File: rtl/cipher_out_serializer.sv
// cipher_out_serializer: buffers 128-bit cipher result blocks and emits them as 32-bit words
// Ports: clk, rst (sync, active-high); vin/tin/din block input without backpressure;
// m_valid/m_ready/m_data/m_type/m_last word output; afull almost-full flag;
// level occupied entries; overflow sticky drop flag cleared by clr_ovf.
module cipher_out_serializer
    import aes_stream_pkg::*;
#(
    parameter int DEPTH = 4,
    parameter int AW = 2,
    parameter int AFULL_FREE = 1
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         vin,
    input  logic         tin,
    input  logic [127:0] din,
    output logic         m_valid,
    input  logic         m_ready,
    output logic [31:0]  m_data,
    output logic         m_type,
    output logic         m_last,
    output logic         afull,
    output logic [AW:0]  level,
    output logic         overflow,
    input  logic         clr_ovf
);
    blk_t head;
    logic full, empty, xfer, pop, push, drop;
    logic [1:0] wcnt;
    logic [AW:0] level_nxt;
    blk_fifo #(.DEPTH(DEPTH), .AW(AW)) u_fifo (
        .clk(clk),
        .rst(rst),
        .push(push),
        .pop(pop),
        .wdata('{typ: tin, data: din}),
        .head(head),
        .level(level),
        .full(full),
        .empty(empty)
    );
    assign m_valid = !empty;
    assign xfer = m_valid && m_ready;
    assign pop = xfer && wcnt == 2'd3;
    // A full buffer still accepts when its head leaves in the same cycle.
    assign push = vin && (!full || pop);
    assign drop = vin && full && !pop;
    assign level_nxt = level + (AW+1)'(push) - (AW+1)'(pop);
    assign m_data = m_valid ? word_sel(head, wcnt) : '0;
    assign m_type = m_valid ? head.typ : TYPE_OUT_ENC;
    assign m_last = m_valid && wcnt == 2'd3;
    always_ff @(posedge clk) begin
        if (rst) begin
            wcnt <= '0;
            overflow <= 1'b0;
            afull <= DEPTH <= AFULL_FREE;
        end else begin
            if (xfer) wcnt <= wcnt + 2'd1;
            overflow <= drop ? 1'b1 : clr_ovf ? 1'b0 : overflow;
            afull <= (DEPTH - int'(level_nxt)) <= AFULL_FREE;
        end
    end
endmodule

// File: tb/tb_cipher_out_serializer.sv
// tb_cipher_out_serializer: directed self-checking bench for cipher_out_serializer
module tb_cipher_out_serializer;
    logic clk = 0, rst = 1, vin = 0, tin = 0, m_ready = 0, clr_ovf = 0;
    logic [127:0] din = '0;
    logic m_valid, m_type, m_last, afull, overflow;
    logic [31:0] m_data;
    logic [2:0] level;
    int errors = 0, checks = 0;

    cipher_out_serializer #(.DEPTH(4), .AW(2), .AFULL_FREE(1)) dut (
        .clk(clk), .rst(rst), .vin(vin), .tin(tin), .din(din),
        .m_valid(m_valid), .m_ready(m_ready), .m_data(m_data), .m_type(m_type),
        .m_last(m_last), .afull(afull), .level(level), .overflow(overflow), .clr_ovf(clr_ovf)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [31:0] wd(input logic [127:0] b, input int w);
        return b[127-32*w -: 32];
    endfunction

    function automatic logic [127:0] mk(input logic [31:0] base, input int i);
        return {base + 32'(i), base + 32'h100 + 32'(i), base + 32'h200 + 32'(i), base + 32'h300 + 32'(i)};
    endfunction

    task automatic test_reset();
        rst = 1;
        tick();
        tick();
        rst = 0;
        checks++; if (m_valid !== 1'b0) begin errors++; $display("FAIL reset_m_valid got %b exp 0", m_valid); end
        checks++; if (m_last !== 1'b0) begin errors++; $display("FAIL reset_m_last got %b exp 0", m_last); end
        checks++; if (m_type !== 1'b0) begin errors++; $display("FAIL reset_m_type got %b exp 0", m_type); end
        checks++; if (m_data !== 32'h0) begin errors++; $display("FAIL reset_m_data got %h exp 0", m_data); end
        checks++; if (afull !== 1'b0) begin errors++; $display("FAIL reset_afull got %b exp 0", afull); end
        checks++; if (level !== 3'd0) begin errors++; $display("FAIL reset_level got %0d exp 0", level); end
        checks++; if (overflow !== 1'b0) begin errors++; $display("FAIL reset_overflow got %b exp 0", overflow); end
    endtask

    task automatic test_single();
        logic [31:0] exp_w [4] = '{32'h00112233, 32'h44556677, 32'h8899AABB, 32'hCCDDEEFF};
        vin = 1; tin = 0; din = 128'h00112233_44556677_8899AABB_CCDDEEFF; m_ready = 1;
        tick();
        vin = 0;
        for (int i = 0; i < 4; i++) begin
            checks++; if (m_valid !== 1'b1) begin errors++; $display("FAIL single_valid w%0d got %b exp 1", i, m_valid); end
            checks++; if (m_data !== exp_w[i]) begin errors++; $display("FAIL single_data w%0d got %h exp %h", i, m_data, exp_w[i]); end
            checks++; if (m_last !== (i == 3)) begin errors++; $display("FAIL single_last w%0d got %b exp %b", i, m_last, i == 3); end
            checks++; if (m_type !== 1'b0) begin errors++; $display("FAIL single_type w%0d got %b exp 0", i, m_type); end
            tick();
        end
        checks++; if (level !== 3'd0) begin errors++; $display("FAIL single_level_end got %0d exp 0", level); end
        checks++; if (m_valid !== 1'b0) begin errors++; $display("FAIL single_valid_end got %b exp 0", m_valid); end
    endtask

    task automatic test_backpressure();
        logic [3:0] pat = 4'b1001;
        logic [127:0] blk = 128'h00112233_44556677_8899AABB_CCDDEEFF;
        int idx = 0;
        vin = 1; tin = 1; din = blk; m_ready = 0;
        tick();
        vin = 0;
        for (int c = 0; c < 24 && idx < 4; c++) begin
            m_ready = pat[3 - (c % 4)];
            checks++; if (m_data !== wd(blk, idx) || m_valid !== 1'b1) begin errors++; $display("FAIL bp_data c%0d got %h/%b exp %h/1", c, m_data, m_valid, wd(blk, idx)); end
            checks++; if (m_last !== (idx == 3) || m_type !== 1'b1) begin errors++; $display("FAIL bp_last_type c%0d got %b/%b exp %b/1", c, m_last, m_type, idx == 3); end
            tick();
            if (m_ready) idx++;
        end
        m_ready = 0;
        checks++; if (idx !== 4 || m_valid !== 1'b0) begin errors++; $display("FAIL bp_done got words=%0d valid=%b exp 4/0", idx, m_valid); end
    endtask

    task automatic test_burst();
        int lvl;
        m_ready = 0;
        for (int i = 0; i < 6; i++) begin
            vin = 1; tin = 1'(i); din = mk(32'hA000_0000, i);
            tick();
            lvl = (i + 1 > 4) ? 4 : i + 1;
            checks++; if (level !== 3'(lvl)) begin errors++; $display("FAIL burst_level b%0d got %0d exp %0d", i, level, lvl); end
            checks++; if (afull !== (lvl >= 3)) begin errors++; $display("FAIL burst_afull b%0d got %b exp %b", i, afull, lvl >= 3); end
            checks++; if (overflow !== (i >= 4)) begin errors++; $display("FAIL burst_overflow b%0d got %b exp %b", i, overflow, i >= 4); end
        end
        vin = 0; m_ready = 1;
        for (int b = 0; b < 4; b++)
            for (int w = 0; w < 4; w++) begin
                checks++; if (m_data !== wd(mk(32'hA000_0000, b), w)) begin errors++; $display("FAIL burst_data b%0d w%0d got %h exp %h", b, w, m_data, wd(mk(32'hA000_0000, b), w)); end
                checks++; if (m_type !== 1'(b) || m_valid !== 1'b1) begin errors++; $display("FAIL burst_type b%0d w%0d got %b/%b exp %b/1", b, w, m_type, m_valid, 1'(b)); end
                tick();
            end
        checks++; if (m_valid !== 1'b0 || level !== 3'd0) begin errors++; $display("FAIL burst_no_extra got valid=%b level=%0d exp 0/0", m_valid, level); end
        checks++; if (overflow !== 1'b1) begin errors++; $display("FAIL burst_ovf_sticky got %b exp 1", overflow); end
        m_ready = 0; clr_ovf = 1;
        tick();
        clr_ovf = 0;
        checks++; if (overflow !== 1'b0) begin errors++; $display("FAIL burst_ovf_clear got %b exp 0", overflow); end
    endtask

    task automatic test_full_pop();
        logic [127:0] nb = 128'hDEAD0000_DEAD1111_DEAD2222_DEAD3333;
        m_ready = 0;
        for (int i = 0; i < 4; i++) begin
            vin = 1; tin = 0; din = mk(32'hF000_0000, i);
            tick();
        end
        vin = 0; m_ready = 1;
        tick(); tick(); tick();
        checks++; if (m_last !== 1'b1 || level !== 3'd4) begin errors++; $display("FAIL fp_pre got last=%b level=%0d exp 1/4", m_last, level); end
        vin = 1; tin = 1; din = nb;
        tick();
        vin = 0;
        checks++; if (level !== 3'd4) begin errors++; $display("FAIL fp_level got %0d exp 4", level); end
        checks++; if (overflow !== 1'b0) begin errors++; $display("FAIL fp_overflow got %b exp 0", overflow); end
        checks++; if (afull !== 1'b1) begin errors++; $display("FAIL fp_afull got %b exp 1", afull); end
        for (int i = 0; i < 12; i++) tick();
        checks++; if (m_data !== wd(nb, 0) || m_type !== 1'b1) begin errors++; $display("FAIL fp_newblk got %h/%b exp %h/1", m_data, m_type, wd(nb, 0)); end
        for (int i = 0; i < 4; i++) tick();
        checks++; if (m_valid !== 1'b0) begin errors++; $display("FAIL fp_drained got %b exp 0", m_valid); end
        m_ready = 0;
    endtask

    task automatic test_ovf_clr();
        m_ready = 0;
        for (int i = 0; i < 4; i++) begin
            vin = 1; tin = 0; din = mk(32'h5000_0000, i);
            tick();
        end
        checks++; if (overflow !== 1'b0) begin errors++; $display("FAIL oc_pre got %b exp 0", overflow); end
        clr_ovf = 1;
        tick();
        vin = 0;
        checks++; if (overflow !== 1'b1) begin errors++; $display("FAIL oc_set_prio got %b exp 1", overflow); end
        tick();
        clr_ovf = 0;
        checks++; if (overflow !== 1'b0) begin errors++; $display("FAIL oc_clear got %b exp 0", overflow); end
        rst = 1;
        tick();
        rst = 0;
    endtask

    task automatic test_reset_mid();
        logic [127:0] a = 128'h11111111_22222222_33333333_44444444;
        logic [127:0] b = 128'h55555555_66666666_77777777_88888888;
        m_ready = 0;
        for (int i = 0; i < 5; i++) begin
            vin = 1; tin = 0; din = a;
            tick();
        end
        vin = 0; m_ready = 1;
        tick(); tick();
        checks++; if (m_data !== wd(a, 2)) begin errors++; $display("FAIL rm_pre got %h exp %h", m_data, wd(a, 2)); end
        rst = 1;
        tick();
        rst = 0;
        checks++; if (m_valid !== 1'b0 || level !== 3'd0 || overflow !== 1'b0) begin errors++; $display("FAIL rm_cleared got valid=%b level=%0d ovf=%b exp 0/0/0", m_valid, level, overflow); end
        tick();
        checks++; if (m_valid !== 1'b0) begin errors++; $display("FAIL rm_no_leftover got %b exp 0", m_valid); end
        vin = 1; tin = 1; din = b;
        tick();
        vin = 0;
        for (int w = 0; w < 4; w++) begin
            checks++; if (m_data !== wd(b, w) || m_last !== (w == 3)) begin errors++; $display("FAIL rm_newblk w%0d got %h/%b exp %h/%b", w, m_data, m_last, wd(b, w), w == 3); end
            tick();
        end
        m_ready = 0;
    endtask

    initial begin
        test_reset();
        test_single();
        test_backpressure();
        test_burst();
        test_full_pop();
        test_ovf_clr();
        test_reset_mid();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
